// File: rtl/chip8_sprite_drawer.sv
// Chip-8 framebuffer writer: executes DRW (row-by-row sprite XOR with clipping and
// collision detection) and CLS, fetching sprite bytes through a 1-cycle read port.
module chip8_sprite_drawer (
    input  logic          clk50,
    input  logic          reset,
    input  logic          start,
    input  logic          clear,
    input  logic [7:0]    x,
    input  logic [7:0]    y,
    input  logic [3:0]    n,
    input  logic [11:0]   sprite_addr,
    output logic [11:0]   mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_data,
    output logic          busy,
    output logic          done,
    output logic          collision,
    output logic [2047:0] framebuffer
);
    localparam int SCREEN_W = 64;
    localparam int SCREEN_H = 32;

    typedef enum logic [1:0] {IDLE, READ, DRAW, DONE} state_t;

    state_t        state_q, state_d;
    logic [5:0]    x0_q, x0_d;
    logic [4:0]    y0_q, y0_d;
    logic [3:0]    n_q, n_d;
    logic [11:0]   base_q, base_d;
    logic [3:0]    row_q, row_d;
    logic [2047:0] fb_q, fb_d;
    logic          coll_q, coll_d;
    logic [11:0]   mem_addr_q, mem_addr_d;
    logic          mem_rd_q, mem_rd_d;
    logic          done_q, done_d;

    // Datapath for the row currently being drawn.
    logic [5:0]  row_sum;
    logic [6:0]  col;
    logic [63:0] row_mask;
    logic [63:0] row_bits;
    logic        hit;

    always_comb begin
        row_sum  = {1'b0, y0_q} + {2'b0, row_q};
        row_mask = '0;
        col      = '0;
        // Sprite columns past the right edge are clipped, never wrapped.
        for (int k = 0; k < 8; k++) begin
            col = {1'b0, x0_q} + 7'(k);
            if (!col[6] && mem_data[3'(7 - k)]) begin
                row_mask[col[5:0]] = 1'b1;
            end
        end
        row_bits = fb_q[{row_sum[4:0], 6'd0} +: SCREEN_W];
        hit      = |(row_bits & row_mask);
    end

    always_comb begin
        // NOTE: every combinational output gets its default first so no path
        // through the case below can leave a signal unassigned and infer a latch.
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        n_d        = n_q;
        base_d     = base_q;
        row_d      = row_q;
        fb_d       = fb_q;
        coll_d     = coll_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (clear) begin
                    fb_d   = '0;
                    coll_d = 1'b0;
                    done_d = 1'b1;
                end else if (start) begin
                    x0_d   = 6'(x % 8'(SCREEN_W));
                    y0_d   = 5'(y % 8'(SCREEN_H));
                    n_d    = n;
                    base_d = sprite_addr;
                    row_d  = '0;
                    coll_d = 1'b0;
                    if (n == 4'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = READ;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = sprite_addr;
                    end
                end
            end
            READ: state_d = DRAW;
            DRAW: begin
                // Rows below the bottom edge still cost a fetch, keeping timing n-only.
                if (!row_sum[5]) begin
                    fb_d[{row_sum[4:0], 6'd0} +: SCREEN_W] = row_bits ^ row_mask;
                    coll_d = coll_q | hit;
                end
                row_d = row_q + 4'd1;
                if (row_d == n_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d    = READ;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = base_q + {8'd0, row_d};
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together at the edge; the framebuffer is a register file with a defined
    // reset value, so it is reset along with the control state.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            n_q        <= '0;
            base_q     <= '0;
            row_q      <= '0;
            fb_q       <= '0;
            coll_q     <= 1'b0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            n_q        <= n_d;
            base_q     <= base_d;
            row_q      <= row_d;
            fb_q       <= fb_d;
            coll_q     <= coll_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            done_q     <= done_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign collision   = coll_q;
    assign framebuffer = fb_q;
endmodule

// File: tb/tb_chip8_sprite_drawer.sv
// Bench for chip8_sprite_drawer: directed and randomized draws checked against a
// pixel-level reference model of DRW/CLS with a registered sprite memory.
module tb_chip8_sprite_drawer;
    logic          clk50 = 1'b0;
    logic          reset, start, clear;
    logic [7:0]    x, y;
    logic [3:0]    n;
    logic [11:0]   sprite_addr;
    logic [11:0]   mem_addr;
    logic          mem_rd;
    logic [7:0]    mem_data;
    logic          busy, done, collision;
    logic [2047:0] framebuffer;

    logic [7:0]    mem [4096];
    logic [2047:0] model_fb;
    int            vectors = 0;
    int            miscompares = 0;

    chip8_sprite_drawer dut (
        .clk50(clk50), .reset(reset), .start(start), .clear(clear),
        .x(x), .y(y), .n(n), .sprite_addr(sprite_addr),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .busy(busy), .done(done), .collision(collision), .framebuffer(framebuffer)
    );

    always #10 clk50 = ~clk50;

    always @(posedge clk50) if (mem_rd) mem_data <= mem[mem_addr];

    function automatic int first_diff(input logic [2047:0] a, input logic [2047:0] b);
        for (int i = 0; i < 2048; i++) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    // Reference: apply DRW to model_fb pixel by pixel using screen coordinates.
    task automatic model_draw(input logic [7:0] dx, input logic [7:0] dy, input logic [3:0] dn,
                              input logic [11:0] da, output bit coll);
        int x0, y0, col, row, idx;
        logic [7:0] b;
        x0 = dx % 64;
        y0 = dy % 32;
        coll = 0;
        for (int r = 0; r < int'(dn); r++) begin
            b = mem[(int'(da) + r) % 4096];
            for (int k = 0; k < 8; k++) begin
                if (b[7 - k]) begin
                    col = x0 + k;
                    row = y0 + r;
                    if (col < 64 && row < 32) begin
                        idx = row * 64 + col;
                        if (model_fb[idx]) coll = 1;
                        model_fb[idx] = ~model_fb[idx];
                    end
                end
            end
        end
    endtask

    task automatic cmp_fb(input string name);
        vectors++;
        if (framebuffer !== model_fb) begin
            miscompares++;
            $display("FAIL %s framebuffer: first diff bit %0d, ones got %0d want %0d", name,
                     first_diff(framebuffer, model_fb), $countones(framebuffer), $countones(model_fb));
        end
    endtask

    task automatic run_draw(input logic [7:0] dx, input logic [7:0] dy, input logic [3:0] dn,
                            input logic [11:0] da, input bit scramble, input string name);
        bit exp_coll;
        int exp_cycles, done_cycle, busy_cnt;
        logic [11:0] seen[$];
        model_draw(dx, dy, dn, da, exp_coll);
        exp_cycles = (dn == 0) ? 1 : 2 * int'(dn) + 1;
        @(negedge clk50);
        x = dx; y = dy; n = dn; sprite_addr = da; start = 1'b1;
        @(posedge clk50); #1;
        start = 1'b0;
        done_cycle = 0;
        busy_cnt = 0;
        for (int c = 1; c <= 40 && done_cycle == 0; c++) begin
            if (busy) busy_cnt++;
            if (mem_rd) seen.push_back(mem_addr);
            if (done) done_cycle = c;
            if (done_cycle == 0) begin
                if (scramble) begin
                    x = 8'($urandom); y = 8'($urandom); n = 4'($urandom);
                    sprite_addr = 12'($urandom); clear = 1'b1; start = 1'($urandom);
                end
                @(posedge clk50); #1;
            end
        end
        start = 1'b0;
        clear = 1'b0;
        vectors++;
        if (done_cycle != exp_cycles) begin
            miscompares++;
            $display("FAIL %s done_cycle: got %0d want %0d (0 = timeout)", name, done_cycle, exp_cycles);
        end
        vectors++;
        if (busy_cnt != exp_cycles) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, exp_cycles);
        end
        vectors++;
        if (seen.size() != int'(dn)) begin
            miscompares++;
            $display("FAIL %s read_count: got %0d want %0d", name, seen.size(), dn);
        end else begin
            for (int i = 0; i < seen.size(); i++) begin
                vectors++;
                if (seen[i] !== 12'((int'(da) + i) % 4096)) begin
                    miscompares++;
                    $display("FAIL %s read_addr[%0d]: got %h want %h", name, i, seen[i],
                             12'((int'(da) + i) % 4096));
                end
            end
        end
        vectors++;
        if (collision !== exp_coll) begin
            miscompares++;
            $display("FAIL %s collision: got %b want %b", name, collision, exp_coll);
        end
        cmp_fb(name);
        @(posedge clk50); #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle_after: busy %b done %b want 0 0", name, busy, done);
        end
    endtask

    task automatic do_clear();
        @(negedge clk50); clear = 1'b1;
        @(posedge clk50); #1; clear = 1'b0;
        model_fb = '0;
    endtask

    task automatic test_reset();
        vectors++;
        if (framebuffer !== '0 || busy !== 0 || done !== 0 || collision !== 0 ||
            mem_rd !== 0 || mem_addr !== 12'h000) begin
            miscompares++;
            $display("FAIL reset: fb_ones %0d busy %b done %b coll %b rd %b addr %h, want all 0",
                     $countones(framebuffer), busy, done, collision, mem_rd, mem_addr);
        end
    endtask

    task automatic test_font();
        mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
        mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;
        run_draw(8'd0, 8'd0, 4'd5, 12'h050, 1'b0, "font");
        vectors++;
        if (framebuffer[3:0] !== 4'hF || framebuffer[67:64] !== 4'h9 || framebuffer[131:128] !== 4'h9 ||
            framebuffer[195:192] !== 4'h9 || framebuffer[259:256] !== 4'hF ||
            $countones(framebuffer) != 14) begin
            miscompares++;
            $display("FAIL font_pixels: rows %h %h %h %h %h ones %0d, want F 9 9 9 F ones 14",
                     framebuffer[3:0], framebuffer[67:64], framebuffer[131:128],
                     framebuffer[195:192], framebuffer[259:256], $countones(framebuffer));
        end
        run_draw(8'd0, 8'd0, 4'd5, 12'h050, 1'b0, "font_redraw");
        vectors++;
        if (framebuffer !== '0 || collision !== 1'b1) begin
            miscompares++;
            $display("FAIL font_erase: ones %0d coll %b, want 0 1", $countones(framebuffer), collision);
        end
    endtask

    task automatic test_clipping();
        mem[12'h200] = 8'hFF; mem[12'h201] = 8'hFF; mem[12'h202] = 8'hFF;
        run_draw(8'd60, 8'd30, 4'd3, 12'h200, 1'b0, "clip");
        vectors++;
        if (framebuffer[30*64+60 +: 4] !== 4'hF || framebuffer[31*64+60 +: 4] !== 4'hF ||
            framebuffer[63:0] !== '0 || framebuffer[30*64] !== 1'b0 || $countones(framebuffer) != 8) begin
            miscompares++;
            $display("FAIL clip_pixels: r30 %h r31 %h row0 %h ones %0d, want F F 0 8",
                     framebuffer[30*64+60 +: 4], framebuffer[31*64+60 +: 4], framebuffer[63:0],
                     $countones(framebuffer));
        end
    endtask

    task automatic test_clear_priority();
        bit bad;
        @(negedge clk50);
        clear = 1'b1; start = 1'b1; x = 8'd1; y = 8'd1; n = 4'd3; sprite_addr = 12'h200;
        @(posedge clk50); #1;
        clear = 1'b0; start = 1'b0;
        model_fb = '0;
        vectors++;
        if (framebuffer !== '0 || done !== 1'b1 || busy !== 1'b0 || mem_rd !== 1'b0 || collision !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_prio: ones %0d done %b busy %b rd %b coll %b, want 0 1 0 0 0",
                     $countones(framebuffer), done, busy, mem_rd, collision);
        end
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk50); #1;
            if (mem_rd !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad = 1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL clear_prio_after: start not dropped (rd/busy/done seen), want quiet");
        end
    endtask

    task automatic test_origin_wrap();
        mem[12'h210] = 8'h80;
        run_draw(8'd71, 8'd33, 4'd1, 12'h210, 1'b0, "origin_wrap");
        vectors++;
        if (framebuffer[71] !== 1'b1 || $countones(framebuffer) != 1) begin
            miscompares++;
            $display("FAIL origin_wrap_bit: bit71 %b ones %0d, want 1 1", framebuffer[71], $countones(framebuffer));
        end
    endtask

    task automatic test_addr_wrap();
        mem[12'hFFE] = 8'hA5; mem[12'hFFF] = 8'h3C; mem[12'h000] = 8'hC3;
        run_draw(8'd10, 8'd5, 4'd3, 12'hFFE, 1'b0, "addr_wrap");
    endtask

    task automatic test_n_zero();
        run_draw(8'd5, 8'd5, 4'd0, 12'h123, 1'b0, "n_zero");
    endtask

    task automatic test_clear_during_draw();
        mem[12'h300] = 8'h81; mem[12'h301] = 8'h42; mem[12'h302] = 8'h24; mem[12'h303] = 8'h18;
        run_draw(8'd20, 8'd12, 4'd4, 12'h300, 1'b1, "clear_in_draw");
    endtask

    task automatic test_random();
        logic [7:0] dx, dy;
        logic [3:0] dn;
        logic [11:0] da;
        for (int t = 0; t < 24; t++) begin
            dx = 8'($urandom); dy = 8'($urandom);
            dn = 4'($urandom_range(0, 15)); da = 12'($urandom);
            for (int i = 0; i < int'(dn); i++) mem[(int'(da) + i) % 4096] = 8'($urandom);
            run_draw(dx, dy, dn, da, 1'($urandom), "random");
        end
    endtask

    task automatic test_reset_mid_draw();
        for (int i = 0; i < 5; i++) mem[12'h400 + 12'(i)] = 8'hFF;
        @(negedge clk50);
        x = 8'd0; y = 8'd0; n = 4'd5; sprite_addr = 12'h400; start = 1'b1;
        @(posedge clk50); #1;
        start = 1'b0;
        repeat (3) @(posedge clk50);
        #5;
        reset = 1'b1;
        #1;
        vectors++;
        if (framebuffer !== '0 || busy !== 0 || done !== 0 || collision !== 0 ||
            mem_rd !== 0 || mem_addr !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_mid_draw: fb_ones %0d busy %b done %b coll %b rd %b addr %h, want all 0",
                     $countones(framebuffer), busy, done, collision, mem_rd, mem_addr);
        end
        @(negedge clk50);
        reset = 1'b0;
        model_fb = '0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; clear = 1'b0;
        x = '0; y = '0; n = '0; sprite_addr = '0;
        model_fb = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk50);
        reset = 1'b0;
        @(posedge clk50); #1;
        test_reset();
        test_font();
        test_clipping();
        test_clear_priority();
        test_origin_wrap();
        test_addr_wrap();
        test_n_zero();
        test_clear_during_draw();
        do_clear();
        test_random();
        test_reset_mid_draw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
